mod_bit_framer: RTL and testbench

Upstream stage of `digital_modulator`. It accepts a byte stream over a valid/ready handshake and serialises it MSB-first into the modulator's framed bit interface: `o_en` bursts, `o_data_vld`/`o_data`, and `o_mod`. Each 8-cycle frame carries 1, 2, 4 or 6 data bits, selected by the modulation code latched at burst start.

---
 rtl/mod_bit_framer.sv | 164 ++++++++++++++++
 tb/tb_mod_bit_framer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_bit_framer.sv
// rtl/mod_bit_framer.sv - byte stream to 8-cycle framed serial bits for digital_modulator
// Optional MOD_FRAMER_PRBS_EN: padded frames carry PRBS-9 bits instead of zeros.
module mod_bit_framer #(
    parameter int BURST_FRAMES = 10,
    parameter int GAP_CYCLES   = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic [1:0] i_mod,
    input  logic       i_byte_vld,
    input  logic [7:0] i_byte,
    output logic       o_byte_rdy,
    output logic       o_en,
    output logic       o_data_vld,
    output logic       o_data,
    output logic [1:0] o_mod,
    output logic       o_underrun
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    localparam logic [15:0] LAST_FRAME = 16'(BURST_FRAMES - 1);
    localparam logic [15:0] LAST_GAP   = 16'(GAP_CYCLES - 1);

    function automatic logic [4:0] bits_per_frame(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd1;
            2'd1:    return 5'd2;
            2'd2:    return 5'd4;
            default: return 5'd6;
        endcase
    endfunction

    state_t      r_state;
    logic [15:0] r_buf;
    logic [4:0]  r_cnt;
    logic [2:0]  r_fcnt;
    logic [15:0] r_frame;
    logic [15:0] r_gcnt;
    logic        r_pad;

    logic [4:0]  w_n_req;
    logic [4:0]  w_n_cur;
    logic        w_start;
    logic        w_last_cyc;
    logic        w_last_frame;
    logic        w_new_frame;
    logic        w_fill;
    logic        w_mid_bit;
    logic        w_pop;
    logic        w_acc;
    logic [15:0] w_shift;
    logic [4:0]  w_cnt_rem;
    logic [15:0] w_buf_next;
    logic [4:0]  w_cnt_next;
    logic        w_pad_bit;

    assign o_byte_rdy   = (r_cnt <= 5'd8);
    assign w_n_req      = bits_per_frame(i_mod);
    assign w_n_cur      = bits_per_frame(o_mod);
    assign w_start      = (r_state == S_IDLE) && i_go && (r_cnt >= w_n_req);
    assign w_last_cyc   = (r_fcnt == 3'd7);
    assign w_last_frame = (r_frame == LAST_FRAME);
    assign w_new_frame  = (r_state == S_BURST) && w_last_cyc && !w_last_frame;
    assign w_fill       = (r_cnt >= w_n_cur);
    assign w_mid_bit    = (r_state == S_BURST) && !w_last_cyc && (({2'b00, r_fcnt} + 5'd1) < w_n_cur);

    // Outputs for cycle c+1 are computed at the edge ending cycle c, so a pop here feeds o_data next cycle.
    assign w_pop        = w_start || (w_new_frame && w_fill) || (w_mid_bit && !r_pad);
    assign w_acc        = i_byte_vld && o_byte_rdy;
    assign w_shift      = w_pop ? {r_buf[14:0], 1'b0} : r_buf;
    assign w_cnt_rem    = r_cnt - {4'd0, w_pop};
    assign w_buf_next   = w_acc ? (w_shift | ({i_byte, 8'h00} >> w_cnt_rem)) : w_shift;
    assign w_cnt_next   = w_acc ? (w_cnt_rem + 5'd8) : w_cnt_rem;

`ifdef MOD_FRAMER_PRBS_EN
    logic [8:0] r_prbs;
    logic       w_pad_emit;

    assign w_pad_emit = (w_new_frame && !w_fill) || (w_mid_bit && r_pad);
    assign w_pad_bit  = r_prbs[8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prbs <= 9'h1FF;
        end else if (w_pad_emit) begin
            r_prbs <= {r_prbs[7:0], r_prbs[8] ^ r_prbs[4]};
        end
    end
`else
    assign w_pad_bit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_buf      <= 16'h0000;
            r_cnt      <= 5'd0;
            r_fcnt     <= 3'd0;
            r_frame    <= 16'd0;
            r_gcnt     <= 16'd0;
            r_pad      <= 1'b0;
            o_en       <= 1'b0;
            o_data_vld <= 1'b0;
            o_data     <= 1'b0;
            o_mod      <= 2'd0;
            o_underrun <= 1'b0;
        end else begin
            r_buf      <= w_buf_next;
            r_cnt      <= w_cnt_next;
            o_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_BURST;
                        o_mod      <= i_mod;
                        o_en       <= 1'b1;
                        o_data_vld <= 1'b1;
                        o_data     <= r_buf[15];
                        r_fcnt     <= 3'd0;
                        r_frame    <= 16'd0;
                        r_pad      <= 1'b0;
                    end
                end
                S_BURST: begin
                    if (w_last_cyc) begin
                        if (w_last_frame) begin
                            r_state    <= S_GAP;
                            o_en       <= 1'b0;
                            o_data_vld <= 1'b0;
                            r_gcnt     <= 16'd0;
                        end else begin
                            // Pad-or-data is fixed here for the whole frame.
                            r_fcnt     <= 3'd0;
                            r_frame    <= r_frame + 16'd1;
                            r_pad      <= !w_fill;
                            o_underrun <= !w_fill;
                            o_data_vld <= 1'b1;
                            o_data     <= w_fill ? r_buf[15] : w_pad_bit;
                        end
                    end else begin
                        r_fcnt <= r_fcnt + 3'd1;
                        if (w_mid_bit) begin
                            o_data_vld <= 1'b1;
                            o_data     <= r_pad ? w_pad_bit : r_buf[15];
                        end else begin
                            o_data_vld <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gcnt == LAST_GAP) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_bit_framer.sv
// tb/tb_mod_bit_framer.sv - directed self-checking bench for mod_bit_framer
module tb_mod_bit_framer;

    localparam int GAP = 20;

    logic       clk = 1'b0;
    logic       i_rst, i_go, i_byte_vld;
    logic [1:0] i_mod;
    logic [7:0] i_byte;
    logic       o_byte_rdy, o_en, o_data_vld, o_data, o_underrun;
    logic [1:0] o_mod;

    always #5 clk = ~clk;

    mod_bit_framer dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_go       (i_go),
        .i_mod      (i_mod),
        .i_byte_vld (i_byte_vld),
        .i_byte     (i_byte),
        .o_byte_rdy (o_byte_rdy),
        .o_en       (o_en),
        .o_data_vld (o_data_vld),
        .o_data     (o_data),
        .o_mod      (o_mod),
        .o_underrun (o_underrun)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] feed_q[$];
    int         fidx;
    bit         feed_on;
    int         n_acc;
    logic       bits_q[$];
    logic       cap_vld[80], cap_dat[80], cap_und[80], cap_en[80], cap_rdy[80];
    logic [1:0] cap_mod[80];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        acc = i_byte_vld & o_byte_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            fidx++;
            n_acc++;
        end
        if (feed_on && fidx < feed_q.size()) begin
            i_byte_vld = 1'b1;
            i_byte     = feed_q[fidx];
        end else begin
            i_byte_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        feed_on    = 0;
        i_byte_vld = 1'b0;
        i_go       = 1'b0;
        i_rst      = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        feed_q.delete();
        bits_q.delete();
        fidx  = 0;
        n_acc = 0;
        tick();
    endtask

    task automatic wait_en();
        int t = 0;
        while (!o_en && t < 400) begin
            tick();
            t++;
        end
        if (!o_en) chk("en_timeout", o_en, 1);
    endtask

    task automatic capture(input int sw_at, input logic [1:0] sw_mod);
        wait_en();
        for (int c = 0; c < 80; c++) begin
            if (c == sw_at) i_mod = sw_mod;
            cap_vld[c] = o_data_vld;
            cap_dat[c] = o_data;
            cap_und[c] = o_underrun;
            cap_en[c]  = o_en;
            cap_rdy[c] = o_byte_rdy;
            cap_mod[c] = o_mod;
            if (o_data_vld) bits_q.push_back(o_data);
            tick();
        end
    endtask

    task automatic check_frames(input string tag, input int n, input logic [1:0] m);
        int e = 0;
        for (int c = 0; c < 80; c++) begin
            logic exp_v;
            exp_v = ((c % 8) < n);
            if (cap_vld[c] !== exp_v) e++;
            if (cap_en[c] !== 1'b1) e++;
            if (cap_mod[c] !== m) e++;
        end
        chk(tag, e, 0);
    endtask

    task automatic check_gap(input string tag);
        int g = 0;
        while (!o_en && g < 100) begin
            g++;
            tick();
        end
        chk(tag, {63'd0, (g >= GAP && g <= GAP + 1)}, 1);
    endtask

    function automatic logic [63:0] got_bits(input int from, input int n);
        logic [63:0] v = '0;
        for (int i = from; i < from + n; i++)
            v = {v[62:0], (i < bits_q.size()) ? bits_q[i] : 1'bx};
        return v;
    endfunction

    function automatic logic [63:0] exp_bits(input int from, input int n);
        logic [63:0] v = '0;
        logic [7:0]  b;
        for (int i = from; i < from + n; i++) begin
            b = feed_q[i / 8];
            v = {v[62:0], b[7 - (i % 8)]};
        end
        return v;
    endfunction

    function automatic logic [63:0] und_mask();
        logic [63:0] m = '0;
        for (int f = 0; f < 10; f++) begin
            m[f] = cap_und[f * 8];
            for (int j = 1; j < 8; j++)
                if (cap_und[f * 8 + j]) m[10 + f] = 1'b1;
        end
        return m;
    endfunction

    function automatic int und_cnt(input int nf);
        int n = 0;
        for (int c = 0; c < nf * 8; c++)
            if (cap_und[c]) n++;
        return n;
    endfunction

    initial begin
        i_rst = 1'b1; i_go = 1'b0; i_mod = 2'd0; i_byte_vld = 1'b0; i_byte = 8'h00;
        feed_on = 0; fidx = 0; n_acc = 0;
        #12;
        chk("rst_en", o_en, 0);
        chk("rst_vld", o_data_vld, 0);
        chk("rst_data", o_data, 0);
        chk("rst_mod", o_mod, 0);
        chk("rst_und", o_underrun, 0);
        chk("rst_rdy", o_byte_rdy, 1);

        // BPSK with two preloaded bytes
        do_reset();
        feed_q = '{8'hA5, 8'h3C};
        i_mod = 2'd0; feed_on = 1;
        repeat (4) tick();
        chk("bpsk_full_rdy", o_byte_rdy, 0);
        i_go = 1'b1;
        capture(-1, 2'd0);
        check_frames("bpsk_frames", 1, 2'd0);
        chk("bpsk_und1", und_cnt(10), 0);
        check_gap("bpsk_gap");
        capture(-1, 2'd0);
        chk("bpsk_und2", und_cnt(6), 0);
        chk("bpsk_bits", got_bits(0, 16), 64'hA53C);

        // 64QAM with continuous supply
        do_reset();
        for (int i = 0; i < 24; i++) feed_q.push_back(8'(i * 37 + 11));
        i_mod = 2'd3; feed_on = 1; i_go = 1'b1;
        capture(-1, 2'd0);
        check_frames("qam_frames", 6, 2'd3);
        chk("qam_und", und_cnt(10), 0);
        chk("qam_bits0", got_bits(0, 60), exp_bits(0, 60));
        check_gap("qam_gap");
        capture(-1, 2'd0);
        check_frames("qam_frames2", 6, 2'd3);
        chk("qam_bits1", got_bits(60, 60), exp_bits(60, 60));

        // Mode change mid-burst
        do_reset();
        for (int i = 0; i < 24; i++) feed_q.push_back(8'(i * 53 + 7));
        i_mod = 2'd1; feed_on = 1; i_go = 1'b1;
        capture(30, 2'd2);
        check_frames("mc_frames1", 2, 2'd1);
        check_gap("mc_gap");
        capture(-1, 2'd0);
        check_frames("mc_frames2", 4, 2'd2);
        chk("mc_bits", got_bits(0, 60), exp_bits(0, 60));

        // Underrun, QPSK, single byte
        do_reset();
        feed_q = '{8'hC6};
        i_mod = 2'd1; feed_on = 1; i_go = 1'b1;
        capture(-1, 2'd0);
        check_frames("ur_frames", 2, 2'd1);
        chk("ur_mask", und_mask(), 64'h3F0);
`ifdef MOD_FRAMER_PRBS_EN
        chk("ur_bits", got_bits(0, 20), 64'hC6FF8);
`else
        chk("ur_bits", got_bits(0, 20), 64'hC6000);
`endif

        // Backpressure in BPSK
        do_reset();
        feed_q = '{8'h96, 8'h0F, 8'hE1, 8'h5A};
        i_mod = 2'd0; feed_on = 1;
        repeat (4) tick();
        i_go = 1'b1;
        capture(-1, 2'd0);
        chk("bp_rdy9", cap_rdy[48], 0);
        chk("bp_rdy9_end", cap_rdy[55], 0);
        chk("bp_rdy8", cap_rdy[56], 1);
        chk("bp_rdy_after", cap_rdy[57], 0);
        chk("bp_nacc", n_acc, 3);
        check_gap("bp_gap");
        capture(-1, 2'd0);
        chk("bp_bits", got_bits(0, 20), exp_bits(0, 20));

        // Reset asserted at frame 3 cycle 2 of a 16QAM burst
        do_reset();
        for (int i = 0; i < 24; i++) feed_q.push_back(8'(i * 29 + 3));
        i_mod = 2'd2; feed_on = 1; i_go = 1'b1;
        wait_en();
        repeat (26) tick();
        chk("mr_pre_vld", o_data_vld, 1);
        i_rst = 1'b1;
        #1;
        chk("mr_en", o_en, 0);
        chk("mr_vld", o_data_vld, 0);
        chk("mr_mod", o_mod, 0);
        chk("mr_rdy", o_byte_rdy, 1);
        feed_on = 0; i_byte_vld = 1'b0; i_go = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        feed_q.delete(); bits_q.delete(); fidx = 0; n_acc = 0;
        for (int i = 0; i < 24; i++) feed_q.push_back(8'(i * 71 + 200));
        feed_on = 1; i_go = 1'b1;
        tick();
        capture(-1, 2'd0);
        check_frames("mr_frames", 4, 2'd2);
        chk("mr_bits", got_bits(0, 40), exp_bits(0, 40));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
